// File: rtl/data_unpacker.sv
// rtl/data_unpacker.sv - splits packed N-lane vectors into N/M/1-lane chunks per chain firmware mode.
// Optional DATA_UNPACKER_LANE_COUNT_EN adds lanes_in for partially filled vectors.
module data_unpacker #(
   parameter int N = 8,
   parameter int M = 2,
   parameter int DATA_WIDTH = 32,
   parameter int MAX_CHAINS = 4,
   parameter logic [7:0] PERSONAL_CONFIG_ID = 8'd0,
   parameter logic [MAX_CHAINS*8-1:0] INITIAL_FIRMWARE = '0
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic                          tracing,
   input  logic                          valid_in,
   output logic                          ready_out,
   input  logic                          eof_in,
   input  logic [$clog2(MAX_CHAINS)-1:0] chainId_in,
   input  logic [7:0]                    configId,
   input  logic [7:0]                    configData,
`ifdef DATA_UNPACKER_LANE_COUNT_EN
   input  logic [$clog2(N+1)-1:0]        lanes_in,
`endif
   input  logic [N*DATA_WIDTH-1:0]       vector_in,
   output logic [N*DATA_WIDTH-1:0]       vector_out,
   output logic                          valid_out,
   input  logic                          ready_in,
   output logic                          eof_out
);

   localparam int CW = $clog2(N + 1);
   localparam int VW = N * DATA_WIDTH;

   typedef enum logic {EMPTY, DRAIN} state_t;

   state_t        state;
   logic [7:0]    firmware [MAX_CHAINS];
   logic [VW-1:0] hold;
   logic [CW-1:0] rem;
   logic [CW-1:0] len_q;
   logic          eof_q;

   logic          accept;
   logic          emit;
   logic          last_chunk;
   logic [7:0]    fw_sel;
   logic [CW-1:0] dec_len;
   logic [CW-1:0] load_rem;
   logic [VW-1:0] shifted;
   logic [VW-1:0] nxt_src;
   logic [CW-1:0] nxt_rem;
   logic [CW-1:0] nxt_len;
   logic [CW-1:0] nxt_cnt;
   logic [VW-1:0] nxt_chunk;

   assign valid_out  = (state == DRAIN);
   assign emit       = valid_out & ready_in;
   assign last_chunk = (rem <= len_q);
   // Taking a new vector on the final beat keeps one-vector-per-cycle throughput in mode 0.
   assign ready_out  = tracing & ((rem == '0) | (last_chunk & emit));
   assign accept     = valid_in & ready_out;
   assign eof_out    = valid_out & eof_q & last_chunk;

`ifdef DATA_UNPACKER_LANE_COUNT_EN
   assign load_rem = lanes_in;
`else
   assign load_rem = CW'(N);
`endif

   always_comb begin
      fw_sel = firmware[chainId_in];
      if (fw_sel == 8'd0)
         dec_len = CW'(N);
      else if (fw_sel == 8'd1)
         dec_len = CW'(M);
      else
         dec_len = CW'(1);
   end

   always_comb begin
      shifted = '0;
      for (int i = 0; i < N; i++) begin
         if (i + int'(len_q) < N)
            shifted[i*DATA_WIDTH +: DATA_WIDTH] = hold[(i + int'(len_q))*DATA_WIDTH +: DATA_WIDTH];
      end

      if (accept) begin
         nxt_src = vector_in;
         nxt_rem = load_rem;
         nxt_len = dec_len;
      end else begin
         nxt_src = shifted;
         nxt_rem = last_chunk ? '0 : rem - len_q;
         nxt_len = len_q;
      end

      // A short final chunk only carries the lanes that are still valid.
      nxt_cnt   = (nxt_rem < nxt_len) ? nxt_rem : nxt_len;
      nxt_chunk = '0;
      for (int i = 0; i < N; i++) begin
         if (CW'(i) < nxt_cnt)
            nxt_chunk[i*DATA_WIDTH +: DATA_WIDTH] = nxt_src[i*DATA_WIDTH +: DATA_WIDTH];
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= EMPTY;
         hold       <= '0;
         rem        <= '0;
         len_q      <= CW'(N);
         eof_q      <= 1'b0;
         vector_out <= '0;
         for (int c = 0; c < MAX_CHAINS; c++)
            firmware[c] <= INITIAL_FIRMWARE[c*8 +: 8];
      end else begin
         if (!tracing && configId == PERSONAL_CONFIG_ID) begin
            for (int c = 0; c < MAX_CHAINS - 1; c++)
               firmware[c] <= firmware[c+1];
            firmware[MAX_CHAINS-1] <= configData;
         end

         if (accept || emit) begin
            hold       <= nxt_src;
            rem        <= nxt_rem;
            len_q      <= nxt_len;
            vector_out <= nxt_chunk;
            state      <= (nxt_rem != '0) ? DRAIN : EMPTY;
            if (accept)
               eof_q <= eof_in;
         end
      end
   end

endmodule

// File: tb/tb_data_unpacker.sv
// tb/tb_data_unpacker.sv - table-driven bench for data_unpacker.
module tb_data_unpacker;

   localparam int N  = 8;
   localparam int DW = 32;
   localparam int VW = N * DW;

   logic          clk = 1'b0;
   logic          reset;
   logic          tracing;
   logic          valid_in;
   logic          ready_out;
   logic          eof_in;
   logic [1:0]    chainId_in;
   logic [7:0]    configId;
   logic [7:0]    configData;
`ifdef DATA_UNPACKER_LANE_COUNT_EN
   logic [3:0]    lanes_in;
`endif
   logic [VW-1:0] vector_in;
   logic [VW-1:0] vector_out;
   logic          valid_out;
   logic          ready_in;
   logic          eof_out;

   int n_chk  = 0;
   int n_fail = 0;

   always #5 clk = ~clk;

   data_unpacker dut (
      .clk        (clk),
      .reset      (reset),
      .tracing    (tracing),
      .valid_in   (valid_in),
      .ready_out  (ready_out),
      .eof_in     (eof_in),
      .chainId_in (chainId_in),
      .configId   (configId),
      .configData (configData),
`ifdef DATA_UNPACKER_LANE_COUNT_EN
      .lanes_in   (lanes_in),
`endif
      .vector_in  (vector_in),
      .vector_out (vector_out),
      .valid_out  (valid_out),
      .ready_in   (ready_in),
      .eof_out    (eof_out)
   );

   typedef struct {
      bit trc; bit vin; bit eof; int ch; bit rdy; int base; int lanes;
      bit cfg; int cdat;
      bit e_ro; bit e_vo; bit e_eo; int e_cnt; int e_first;
   } step_t;

   step_t steps[$];

   function automatic logic [VW-1:0] mk_vec(input int first, input int cnt);
      logic [VW-1:0] v;
      v = '0;
      for (int i = 0; i < N; i++)
         if (i < cnt) v[i*DW +: DW] = DW'(first + i);
      return v;
   endfunction

   function automatic step_t st(input bit trc, input bit vin, input bit eof, input int ch,
                                input bit rdy, input int base, input bit cfg, input int cdat,
                                input bit ro, input bit vo, input bit eo, input int cnt,
                                input int first);
      step_t s;
      s.trc = trc; s.vin = vin; s.eof = eof; s.ch = ch; s.rdy = rdy; s.base = base;
      s.lanes = N; s.cfg = cfg; s.cdat = cdat;
      s.e_ro = ro; s.e_vo = vo; s.e_eo = eo; s.e_cnt = cnt; s.e_first = first;
      return s;
   endfunction

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called just after a falling edge: drive, settle, check, advance to the next falling edge.
   task automatic run_step(input step_t s, input string nm);
      tracing    = s.trc;
      valid_in   = s.vin;
      eof_in     = s.eof;
      chainId_in = 2'(s.ch);
      ready_in   = s.rdy;
      vector_in  = mk_vec(s.base, N);
      configId   = s.cfg ? 8'd0 : 8'hFF;
      configData = 8'(s.cdat);
`ifdef DATA_UNPACKER_LANE_COUNT_EN
      lanes_in   = 4'(s.lanes);
`endif
      #1;
      chk({nm, " ready_out"}, VW'(ready_out), VW'(s.e_ro));
      chk({nm, " valid_out"}, VW'(valid_out), VW'(s.e_vo));
      chk({nm, " eof_out"},   VW'(eof_out),   VW'(s.e_eo));
      chk({nm, " vector_out"}, vector_out, mk_vec(s.e_first, s.e_cnt));
      @(negedge clk);
   endtask

   task automatic run_table(input string prefix);
      for (int i = 0; i < steps.size(); i++)
         run_step(steps[i], $sformatf("%s[%0d]", prefix, i));
      steps.delete();
   endtask

   initial begin
      step_t s;
      reset = 1'b1; tracing = 1'b1; valid_in = 1'b0; eof_in = 1'b0; chainId_in = '0;
      configId = 8'hFF; configData = '0; vector_in = '0; ready_in = 1'b1;
`ifdef DATA_UNPACKER_LANE_COUNT_EN
      lanes_in = 4'd8;
`endif
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      chk("reset valid_out", VW'(valid_out), '0);
      chk("reset vector_out", vector_out, '0);
      chk("reset eof_out", VW'(eof_out), '0);
      chk("reset ready_out", VW'(ready_out), VW'(1));
      @(negedge clk);

      // mode 0 back-to-back, then tracing=0 blocks accept while firmware loads {1,2,0,0}
      steps.push_back(st(1,1,1,0,1,10, 0,0, 1,0,0,0,0));
      steps.push_back(st(1,1,0,0,1,20, 0,0, 1,1,1,8,10));
      steps.push_back(st(1,0,0,0,1,0,  0,0, 1,1,0,8,20));
      steps.push_back(st(1,0,0,0,1,0,  0,0, 1,0,0,0,0));
      steps.push_back(st(0,1,0,0,1,30, 1,1, 0,0,0,0,0));
      steps.push_back(st(0,1,0,0,1,30, 1,2, 0,0,0,0,0));
      steps.push_back(st(0,0,0,0,1,0,  1,0, 0,0,0,0,0));
      steps.push_back(st(0,0,0,0,1,0,  1,0, 0,0,0,0,0));
      steps.push_back(st(1,0,0,0,1,0,  1,7, 1,0,0,0,0));
      // mode 1 on chain 0: four 2-lane beats
      steps.push_back(st(1,1,0,0,1,10, 0,0, 1,0,0,0,0));
      steps.push_back(st(1,0,0,0,1,0,  0,0, 0,1,0,2,10));
      steps.push_back(st(1,0,0,0,1,0,  0,0, 0,1,0,2,12));
      steps.push_back(st(1,0,0,0,1,0,  0,0, 0,1,0,2,14));
      steps.push_back(st(1,0,0,0,1,0,  0,0, 1,1,0,2,16));
      steps.push_back(st(1,0,0,0,1,0,  0,0, 1,0,0,0,0));
      // mode 2 on chain 1 with eof and ready_in stalls
      steps.push_back(st(1,1,1,1,1,10, 0,0, 1,0,0,0,0));
      for (int k = 0; k < 8; k++) begin
         steps.push_back(st(1,0,0,0,0,0, 0,0, 0,         1,(k==7),1,10+k));
         steps.push_back(st(1,0,0,0,1,0, 0,0, bit'(k==7),1,(k==7),1,10+k));
      end
      steps.push_back(st(1,0,0,0,1,0, 0,0, 1,0,0,0,0));
      run_table("tbl");

      // reset during beat 2 of a mode-1 drain
      run_step(st(1,1,0,0,1,10, 0,0, 1,0,0,0,0), "rst_acc");
      run_step(st(1,0,0,0,1,0,  0,0, 0,1,0,2,10), "rst_b1");
      tracing = 1'b1; valid_in = 1'b0; ready_in = 1'b1;
      #1;
      chk("rst_b2 vector_out", vector_out, mk_vec(12, 2));
      reset = 1'b1;
      #1;
      chk("rst_mid valid_out", VW'(valid_out), '0);
      chk("rst_mid vector_out", vector_out, '0);
      chk("rst_mid eof_out", VW'(eof_out), '0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      chk("rst_rel ready_out", VW'(ready_out), VW'(1));
      @(negedge clk);
      run_step(st(1,1,1,0,1,40, 0,0, 1,0,0,0,0), "rst_fw_acc");
      run_step(st(1,0,0,0,1,0,  0,0, 1,1,1,8,40), "rst_fw_beat");
      run_step(st(1,0,0,0,1,0,  0,0, 1,0,0,0,0), "rst_fw_idle");

`ifdef DATA_UNPACKER_LANE_COUNT_EN
      steps.push_back(st(0,0,0,0,1,0, 1,1, 0,0,0,0,0));
      for (int k = 0; k < 3; k++)
         steps.push_back(st(0,0,0,0,1,0, 1,0, 0,0,0,0,0));
      s = st(1,1,1,0,1,10, 0,0, 1,0,0,0,0);
      s.lanes = 5;
      steps.push_back(s);
      steps.push_back(st(1,0,0,0,1,0, 0,0, 0,1,0,2,10));
      steps.push_back(st(1,0,0,0,1,0, 0,0, 0,1,0,2,12));
      steps.push_back(st(1,0,0,0,1,0, 0,0, 1,1,1,1,14));
      steps.push_back(st(1,0,0,0,1,0, 0,0, 1,0,0,0,0));
      s = st(1,1,1,0,1,50, 0,0, 1,0,0,0,0);
      s.lanes = 0;
      steps.push_back(s);
      steps.push_back(st(1,0,0,0,1,0, 0,0, 1,0,0,0,0));
      run_table("lanes");
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
